// File: rtl/calib_sched_pkg.sv
// calib_sched_pkg: shared FSM state type and default sizing for the calibration scheduler.
package calib_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    localparam int NUM_CH_DEF  = 4;
    localparam int RES_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     idx
);
    always_comb begin
        logic [IW-1:0] j;
        logic found;
        gnt = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = IW'((int'(ptr) + i) % NUM_CH);
            if (!found && req[j]) begin
                found = 1'b1;
                gnt[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/calib_scheduler.sv
// calib_scheduler: round-robin sharing of one calibration datapath among NUM_CH channels.
// Optional WAIT watchdog enabled by defining CALIB_SCHED_TIMEOUT_EN.
module calib_scheduler
    import calib_sched_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    output logic [NUM_CH-1:0]         ack,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      busy,
    output logic                      calib_start,
    input  logic                      calib_done,
    input  logic [RES_W-1:0]          calib_result,
    output logic [RES_W-1:0]          result,
    output logic                      err
);
    localparam int IW = $clog2(NUM_CH);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       nxt;
    logic [IW-1:0]       gidx;
    logic [NUM_CH-1:0]   gnt;
    logic                to;

    rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    assign nxt         = (ch_sel == IW'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
    assign busy        = state != IDLE;
    assign calib_start = state == START;
    // ack follows the live request so a channel that gave up is never acked
    assign ack = (state == DONE && req[ch_sel]) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_sel) : '0;

`ifdef CALIB_SCHED_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] cnt;
    assign to = state == WAIT && !calib_done && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            err <= to;
        end
    end
`else
    assign to  = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            ch_sel <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    ch_sel <= gidx;
                    state  <= START;
                end
                START: state <= WAIT;
                WAIT: if (calib_done) begin
                    result <= calib_result;
                    state  <= DONE;
                end else if (to) begin
                    ptr   <= nxt;
                    state <= IDLE;
                end
                default: begin
                    ptr   <= nxt;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/calib_scheduler.md
# calib_scheduler

Round-robin scheduler that shares the single compensated-pressure calibration datapath (calibration FSM plus coefficient ROM/ALU/store_reg) among NUM_CH sensor channels. It arbitrates channel requests, drives the channel-select for the Praw/Traw input mux, and issues a one-cycle start to the calibration FSM. It then detects that calculation's done, captures the compensated result, and returns it to the granted channel with a one-cycle ack.

## Interface
- NUM_CH, 4: number of requesting sensor channels (2..8).
- RES_W, 16: width of the calibrated result.
- TIMEOUT, 15: wait-state cycle limit, used only with the watchdog macro.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_CH  per-channel request; a level held until the channel's ack.
- ack  out  NUM_CH  one-hot, one-cycle pulse: result valid for that channel.
- ch_sel  out  $clog2(NUM_CH)  index of the granted channel, feeding the Praw/Traw mux.
- busy  out  1  high from START through DONE.
- calib_start  out  1  start pulse to the calibration FSM.
- calib_done  in  1  done from the calibration FSM; a level held while that FSM is in its final state.
- calib_result  in  RES_W  store_reg output of the datapath.
- result  out  RES_W  registered result, valid while ack is high and held until the next capture.
- err  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If any req bit is set, register the round-robin winner into ch_sel and go to START.
  - Otherwise stay in IDLE.
- START:
  - Assert calib_start for exactly one cycle, then go to WAIT.
  - calib_done may still be high from the previous calculation and is ignored in this state.
- WAIT:
  - Stay until calib_done=1.
  - On that edge, load result<=calib_result and go to DONE.
- DONE:
  - Pulse ack[ch_sel] only if req[ch_sel] is still high.
  - Advance the rr pointer to ch_sel+1, wrapping modulo NUM_CH.
  - Return to IDLE.
- Round-robin:
  - The search starts at the pointer and takes the lowest index at or after it, wrapping.
  - The pointer resets to 0.
- ch_sel is held constant from START through DONE, so the datapath sees stable Praw/Traw for the whole calculation.
- A requester that drops req mid-operation:
  - The calculation still completes and result is still updated.
  - ack is suppressed.
  - The pointer still advances.
- A new req arriving during busy is not seen until the next IDLE.
- Reset values: state IDLE, pointer 0, ch_sel 0, result 0; ack, busy, calib_start and err all 0. Reset mid-operation aborts immediately.
- The calibration FSM shares rst_n, so both blocks come out of reset idle together.

## Timing
- calib_start at cycle S puts the calibration FSM through its four compute states; calib_done is first high at S+4.
- Sequence for req seen in IDLE at cycle 0:
  - START at cycle 1 (calib_start=1).
  - WAIT at cycles 2..5; done is seen at 5 and result is loaded at the end of 5.
  - DONE at cycle 6, with ack and result valid.
  - IDLE at cycle 7.
- Back-to-back: the next grant is registered at cycle 7 and its start occurs at cycle 8, giving 7 cycles per transaction with continuous requests.
- ack never asserts in the same cycle as calib_start. At most one ack bit is high in any cycle.

## Configuration
- CALIB_SCHED_TIMEOUT_EN defined:
  - A 4-bit-minimum counter runs in WAIT.
  - If it reaches TIMEOUT with no calib_done:
    - err pulses for one cycle.
    - result is not updated and ack is suppressed.
    - The pointer advances and the FSM returns to IDLE.
- Not defined: the counter is absent, WAIT is unbounded and err is tied 0.

## Structure
- calib_sched_pkg holds:
  - the state_t enum (IDLE, START, WAIT, DONE);
  - default constants for NUM_CH, RES_W and TIMEOUT.
- Sub-module rr_arbiter:
  - Inputs are req and the pointer; output is the one-hot/index grant.
  - Purely combinational.
  - Pointer register kept in calib_scheduler.
- calib_scheduler holds the FSM, the pointer, the result register and the optional watchdog.

## Test plan
- Single request, req=4'b0100 held, FSM model returns result 16'h1A2B: calib_start at cycle 1, ch_sel=2 from cycle 1, ack=4'b0100 at cycle 6 with result=16'h1A2B, busy low at cycle 7.
- All four requests held, with distinct results per channel: acks arrive in order ch0, ch1, ch2, ch3, ch0, 7 cycles apart, and never two in one cycle.
- Stale done: calib_done held high into the START cycle (FSM model still in its final state) must not be captured; capture occurs only at S+4.
- req[1] dropped at cycle 3: no ack, result updated, and the next grant goes to ch2 if it is requesting.
- rst_n asserted in WAIT: all outputs return to reset values immediately, and the first grant after release is ch0.
- CALIB_SCHED_TIMEOUT_EN defined, calib_done stuck low: err pulses TIMEOUT cycles after entry to WAIT, no ack, FSM back in IDLE.
